// File: rtl/md_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: operation encodings,
// default latencies and the mcalc classification helper.
package md_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    // True for the operations that occupy the unit for a busy period.
    function automatic logic is_mcalc(input logic [2:0] op);
        logic res;
        res = 1'b0;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: res = 1'b1;
            default:                            res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_ctrl_arith.sv
// Combinational 64-bit result generator for mult/multu/div/divu.
// Division yields quotient in lo and remainder in hi; div_zero flags B == 0.
module md_ctrl_arith
    import md_ctrl_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero
);

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        divisor;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;

    assign div_zero = (b == 32'd0);
    // Substitute divisor keeps the dividers well-defined; the result is discarded anyway.
    assign divisor  = div_zero ? 32'd1 : b;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};
    assign quot_s = $signed(a) / $signed(divisor);
    assign rem_s  = $signed(a) % $signed(divisor);
    assign quot_u = a / divisor;
    assign rem_u  = a % divisor;

    always_comb begin
        hi = 32'd0;
        lo = 32'd0;
        case (md_op)
            MD_MULT:  {hi, lo} = prod_s;
            MD_MULTU: {hi, lo} = prod_u;
            MD_DIV: begin
                hi = rem_s;
                lo = quot_s;
            end
            MD_DIVU: begin
                hi = rem_u;
                lo = quot_u;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer beside the E-stage ALU: owns HI/LO, models
// multi-cycle latency with a down-counter and requests F/D stalls.
module md_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        en,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        md_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    logic [CntW-1:0] counter_q, counter_d;
    logic [31:0]     tmp_hi_q, tmp_hi_d;
    logic [31:0]     tmp_lo_q, tmp_lo_d;
    logic            commit_en_q, commit_en_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;

    logic [31:0]     res_hi;
    logic [31:0]     res_lo;
    logic            div_zero;
    logic            issue;

    md_ctrl_arith u_arith (
        .md_op    (md_op),
        .a        (A),
        .b        (B),
        .hi       (res_hi),
        .lo       (res_lo),
        .div_zero (div_zero)
    );

    assign busy  = (counter_q != '0);
    // A start arriving while busy cannot happen under correct stalling; it is dropped.
    assign issue = start & en & ~busy;

    // mthi/mtlo never stall: their write lands before the D-stage instruction reaches E.
    assign stall_md = md_D & (busy | (start & en & is_mcalc(md_op)));

    assign HI = hi_q;
    assign LO = lo_q;

    always_comb begin
        counter_d   = counter_q;
        tmp_hi_d    = tmp_hi_q;
        tmp_lo_d    = tmp_lo_q;
        commit_en_d = commit_en_q;
        hi_d        = hi_q;
        lo_d        = lo_q;

        if (busy) begin
            counter_d = counter_q - CntW'(1);
            if ((counter_q == CntW'(1)) && commit_en_q) begin
                hi_d = tmp_hi_q;
                lo_d = tmp_lo_q;
            end
        end else if (issue) begin
            case (md_op)
                MD_MULT, MD_MULTU: begin
                    tmp_hi_d    = res_hi;
                    tmp_lo_d    = res_lo;
                    counter_d   = CntW'(MULT_CYCLES);
                    commit_en_d = 1'b1;
                end
                MD_DIV, MD_DIVU: begin
                    tmp_hi_d    = res_hi;
                    tmp_lo_d    = res_lo;
                    counter_d   = CntW'(DIV_CYCLES);
                    commit_en_d = ~div_zero;
                end
                MD_MTHI: hi_d = A;
                MD_MTLO: lo_d = A;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            counter_q   <= '0;
            tmp_hi_q    <= 32'd0;
            tmp_lo_q    <= 32'd0;
            commit_en_q <= 1'b0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
        end else begin
            counter_q   <= counter_d;
            tmp_hi_q    <= tmp_hi_d;
            tmp_lo_q    <= tmp_lo_d;
            commit_en_q <= commit_en_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: busy timing, HI/LO commit values, stall behaviour,
// divide-by-zero suppression and mid-operation reset.
module tb_md_ctrl;
    import md_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic        en;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        md_D;
    logic        busy;
    logic        stall_md;
    logic [31:0] HI;
    logic [31:0] LO;

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    md_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .en       (en),
        .md_op    (md_op),
        .A        (A),
        .B        (B),
        .md_D     (md_D),
        .busy     (busy),
        .stall_md (stall_md),
        .HI       (HI),
        .LO       (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue an mcalc op and follow it through its busy period to the commit.
    task automatic run_calc(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int n, input logic d,
                            input logic [31:0] new_hi, input logic [31:0] new_lo);
        @(posedge clk); #1;
        check({tag, "_idle_before"}, 32'(busy), 32'd0);
        md_D = d; start = 1'b1; en = 1'b1; md_op = op; A = a; B = b;
        @(negedge clk);
        check({tag, "_stall_issue"}, 32'(stall_md), 32'(d));
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_stall_busy"}, 32'(stall_md), 32'(d));
            check({tag, "_hi_hold"}, HI, exp_hi);
            check({tag, "_lo_hold"}, LO, exp_lo);
        end
        @(negedge clk);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_stall_done"}, 32'(stall_md), 32'd0);
        check({tag, "_hi"}, HI, new_hi);
        check({tag, "_lo"}, LO, new_lo);
        exp_hi = new_hi;
        exp_lo = new_lo;
        md_D = 1'b0;
    endtask

    // mthi/mtlo with an mt/mf-class instruction in D: no stall, no busy.
    task automatic run_mt(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] new_hi, input logic [31:0] new_lo);
        @(posedge clk); #1;
        md_D = 1'b1; start = 1'b1; en = 1'b1; md_op = op; A = a; B = 32'h5555_5555;
        @(negedge clk);
        check({tag, "_stall"}, 32'(stall_md), 32'd0);
        check({tag, "_hi_before"}, HI, exp_hi);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_stall_after"}, 32'(stall_md), 32'd0);
        check({tag, "_hi"}, HI, new_hi);
        check({tag, "_lo"}, LO, new_lo);
        exp_hi = new_hi;
        exp_lo = new_lo;
        md_D = 1'b0;
    endtask

    // Stimulus that must leave the unit untouched.
    task automatic run_none(input string tag, input logic e, input logic [2:0] op);
        @(posedge clk); #1;
        md_D = 1'b1; start = 1'b1; en = e; md_op = op; A = 32'h1234_5678; B = 32'd3;
        @(negedge clk);
        check({tag, "_stall"}, 32'(stall_md), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check({tag, "_busy"}, 32'(busy), 32'd0);
            check({tag, "_hi"}, HI, exp_hi);
            check({tag, "_lo"}, LO, exp_lo);
        end
        md_D = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1; start = 1'b0; en = 1'b0; md_op = 3'd0;
        A = 32'd0; B = 32'd0; md_D = 1'b0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stall", 32'(stall_md), 32'd0);

        // -3 * 5 = -15 with mflo held in D
        run_calc("mult", MD_MULT, 32'hFFFF_FFFD, 32'd5, 5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_calc("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE);
        // -7 / 2 = -3 rem -1
        run_calc("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_mt("mthi11", MD_MTHI, 32'h0000_0011, 32'h0000_0011, 32'hFFFF_FFFD);
        run_mt("mtlo22", MD_MTLO, 32'h0000_0022, 32'h0000_0011, 32'h0000_0022);
        run_calc("divu0", MD_DIVU, 32'd7, 32'd0, 10, 1'b0, 32'h0000_0011, 32'h0000_0022);
        run_mt("mthi_dead", MD_MTHI, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0022);
        run_calc("divu", MD_DIVU, 32'd100, 32'd7, 10, 1'b0, 32'h0000_0002, 32'h0000_000E);
        // 7 / -2 = -3 rem 1: remainder follows the dividend
        run_calc("div_negb", MD_DIV, 32'd7, 32'hFFFF_FFFE, 10, 1'b0, 32'h0000_0001,
                 32'hFFFF_FFFD);
        run_none("op6", 1'b1, 3'd6);
        run_none("en0", 1'b0, MD_MULT);

        // Reset in cycle t+4 of a divide discards it.
        @(posedge clk); #1;
        start = 1'b1; en = 1'b1; md_op = MD_DIV; A = 32'd100; B = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_mid_busy_before", 32'(busy), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_hi", HI, 32'd0);
        check("rst_mid_lo", LO, 32'd0);
        repeat (12) @(negedge clk);
        check("rst_mid_late_busy", 32'(busy), 32'd0);
        check("rst_mid_late_hi", HI, 32'd0);
        check("rst_mid_late_lo", LO, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
